// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, default
// latencies and FSM state encoding. The instruction decoder uses the same
// md_op encodings.
package md_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MTHI  = 4'd4,
    MD_MTLO  = 4'd5,
    MD_MADD  = 4'd6,
    MD_MADDU = 4'd7,
    MD_MSUB  = 4'd8,
    MD_MSUBU = 4'd9
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Signed variants treat A and B as two's complement.
  function automatic logic md_is_signed(input logic [3:0] op);
    logic s;
    case (op)
      MD_MULT, MD_DIV, MD_MADD, MD_MSUB: s = 1'b1;
      default:                           s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO.
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU
// (accumulate into {HI,LO}); when undefined those codes are no-ops.
// The result is computed in the accept cycle and parked in pending
// registers; HI/LO change only on the last busy cycle so a reset during
// the operation discards it cleanly.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        IntReq,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int CNT_W = 16;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      phi_q, phi_d;
  logic [31:0]      plo_q, plo_d;
  logic             pwr_q, pwr_d;

  logic        go_s;
  logic        sgn_s;
  logic [63:0] prod_s;
  logic        neg_a_s, neg_b_s, b_nz_s;
  logic [31:0] a_mag_s, b_mag_s, b_safe_s, q_mag_s, r_mag_s, quo_s, rem_s;
`ifdef MDU_MADD_EN
  logic [63:0] acc_add_s, acc_sub_s;
`endif

  assign busy   = (state_q == MD_RUN);
  assign md_out = rd_hi ? hi_q : lo_q;
  assign go_s   = start & ~IntReq & ~busy;
  assign sgn_s  = md_is_signed(md_op);

  // 64-bit product: sign-extending to 64 bits makes the truncated product
  // correct for both signed and unsigned operands.
  assign prod_s = {{32{sgn_s & A[31]}}, A} * {{32{sgn_s & B[31]}}, B};

  // Division on magnitudes, then re-apply signs: quotient truncates toward
  // zero and the remainder follows the dividend. B=0 is steered to a safe
  // divisor; its result is never written back.
  assign neg_a_s  = sgn_s & A[31];
  assign neg_b_s  = sgn_s & B[31];
  assign a_mag_s  = neg_a_s ? (32'd0 - A) : A;
  assign b_mag_s  = neg_b_s ? (32'd0 - B) : B;
  assign b_nz_s   = (B != 32'd0);
  assign b_safe_s = b_nz_s ? b_mag_s : 32'd1;
  assign q_mag_s  = a_mag_s / b_safe_s;
  assign r_mag_s  = a_mag_s % b_safe_s;
  assign quo_s    = (neg_a_s ^ neg_b_s) ? (32'd0 - q_mag_s) : q_mag_s;
  assign rem_s    = neg_a_s ? (32'd0 - r_mag_s) : r_mag_s;

`ifdef MDU_MADD_EN
  assign acc_add_s = {hi_q, lo_q} + prod_s;
  assign acc_sub_s = {hi_q, lo_q} - prod_s;
`endif

  // Next-state, counter, pending-result and HI/LO update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    case (state_q)
      MD_IDLE: begin
        if (go_s) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              state_d = MD_RUN;
              cnt_d   = CNT_W'(MULT_CYCLES);
              phi_d   = prod_s[63:32];
              plo_d   = prod_s[31:0];
              pwr_d   = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              state_d = MD_RUN;
              cnt_d   = CNT_W'(DIV_CYCLES);
              phi_d   = rem_s;
              plo_d   = quo_s;
              pwr_d   = b_nz_s;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: begin
              state_d = MD_RUN;
              cnt_d   = CNT_W'(MULT_CYCLES);
              phi_d   = acc_add_s[63:32];
              plo_d   = acc_add_s[31:0];
              pwr_d   = 1'b1;
            end
            MD_MSUB, MD_MSUBU: begin
              state_d = MD_RUN;
              cnt_d   = CNT_W'(MULT_CYCLES);
              phi_d   = acc_sub_s[63:32];
              plo_d   = acc_sub_s[31:0];
              pwr_d   = 1'b1;
            end
`endif
            default: begin
              state_d = MD_IDLE;
            end
          endcase
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_RUN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          pwr_d   = 1'b0;
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit with a high-level arithmetic model of HI/LO.
// Define MDU_MADD_EN for both bench and RTL to exercise the accumulate ops.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        IntReq = 1'b0;
  logic        rd_hi = 1'b0;
  logic        busy;
  logic [31:0] md_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .IntReq(IntReq), .rd_hi(rd_hi), .busy(busy), .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe HI and LO through the read mux.
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    rd_hi = 1'b1; #1; hi = md_out;
    rd_hi = 1'b0; #1; lo = md_out;
  endtask

  // Reference model: applies an op to {hi_m,lo_m}, returns expected busy length.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, output int lat);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 0;
    case (op)
      MD_MULT:  begin p = 64'(sa * sb); {hi_m, lo_m} = p; lat = 5; end
      MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = p; lat = 5; end
      MD_DIV:   begin
        lat = 10;
        if (b != 32'd0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      end
      MD_DIVU:  begin
        lat = 10;
        if (b != 32'd0) begin lo_m = a / b; hi_m = a % b; end
      end
      MD_MTHI:  hi_m = a;
      MD_MTLO:  lo_m = a;
`ifdef MDU_MADD_EN
      MD_MADD:  begin {hi_m, lo_m} = {hi_m, lo_m} + 64'(sa * sb); lat = 5; end
      MD_MADDU: begin {hi_m, lo_m} = {hi_m, lo_m} + {32'd0, a} * {32'd0, b}; lat = 5; end
      MD_MSUB:  begin {hi_m, lo_m} = {hi_m, lo_m} - 64'(sa * sb); lat = 5; end
      MD_MSUBU: begin {hi_m, lo_m} = {hi_m, lo_m} - {32'd0, a} * {32'd0, b}; lat = 5; end
`endif
      default: lat = 0;
    endcase
  endtask

  // Issue one op for a single cycle, then count busy cycles (bounded).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int bcnt);
    start = 1'b1; md_op = op; A = a; B = b;
    tick();
    start = 1'b0;
    bcnt = 0;
    while (busy && bcnt < 100) begin
      bcnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    reset = 1'b1; start = 1'b1; md_op = MD_MTHI; A = 32'h55;
    tick(); tick();
    reset = 1'b0; start = 1'b0;
    read_hilo(h, l);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (h !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", h); end
    n_checks++; if (l !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", l); end
    hi_m = 32'd0; lo_m = 32'd0;
  endtask

  task automatic test_mult();
    int bc; logic [31:0] h, l;
    do_op(MD_MULT, 32'hFFFFFFFE, 32'd3, bc);
    read_hilo(h, l);
    n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL mult_busy got %0d want 5", bc); end
    n_checks++; if (h !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", h); end
    n_checks++; if (l !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo got %h want fffffffa", l); end
    do_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, bc);
    read_hilo(h, l);
    n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL multu_busy got %0d want 5", bc); end
    n_checks++; if (h !== 32'h00000002) begin n_fail++; $display("FAIL multu_hi got %h want 00000002", h); end
    n_checks++; if (l !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL multu_lo got %h want fffffffa", l); end
    hi_m = h; lo_m = 32'hFFFFFFFA;
  endtask

  task automatic test_div();
    int bc; logic [31:0] h, l;
    do_op(MD_DIV, 32'hFFFFFFF9, 32'd2, bc);
    read_hilo(h, l);
    n_checks++; if (bc !== 10) begin n_fail++; $display("FAIL div_busy got %0d want 10", bc); end
    n_checks++; if (l !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", l); end
    n_checks++; if (h !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", h); end
    do_op(MD_DIVU, 32'd7, 32'd2, bc);
    read_hilo(h, l);
    n_checks++; if (l !== 32'd3) begin n_fail++; $display("FAIL divu_lo got %h want 3", l); end
    n_checks++; if (h !== 32'd1) begin n_fail++; $display("FAIL divu_hi got %h want 1", h); end
    hi_m = 32'd1; lo_m = 32'd3;
  endtask

  task automatic test_mt_divzero();
    int bc; logic [31:0] h, l;
    do_op(MD_MTHI, 32'h11, 32'd0, bc);
    rd_hi = 1'b1; #1;
    n_checks++; if (md_out !== 32'h11) begin n_fail++; $display("FAIL mthi_next got %h want 11", md_out); end
    n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL mthi_busy got %0d want 0", bc); end
    do_op(MD_MTLO, 32'h22, 32'd0, bc);
    rd_hi = 1'b0; #1;
    n_checks++; if (md_out !== 32'h22) begin n_fail++; $display("FAIL mtlo_next got %h want 22", md_out); end
    do_op(MD_DIV, 32'd1234, 32'd0, bc);
    read_hilo(h, l);
    n_checks++; if (bc !== 10) begin n_fail++; $display("FAIL div0_busy got %0d want 10", bc); end
    n_checks++; if (h !== 32'h11) begin n_fail++; $display("FAIL div0_hi got %h want 11", h); end
    n_checks++; if (l !== 32'h22) begin n_fail++; $display("FAIL div0_lo got %h want 22", l); end
    hi_m = 32'h11; lo_m = 32'h22;
  endtask

  task automatic test_cancel();
    int bc; logic [31:0] h, l;
    start = 1'b1; IntReq = 1'b1; md_op = MD_MULT; A = 32'd9; B = 32'd9;
    tick();
    start = 1'b0; IntReq = 1'b0;
    read_hilo(h, l);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %b want 0", busy); end
    n_checks++; if ({h, l} !== {hi_m, lo_m}) begin n_fail++; $display("FAIL cancel_hilo got %h want %h", {h, l}, {hi_m, lo_m}); end
    start = 1'b1; md_op = MD_MULT; A = 32'd7; B = 32'd6;
    tick();
    start = 1'b0;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      if (bc == 1) begin
        read_hilo(h, l);
        n_checks++; if (l !== lo_m) begin n_fail++; $display("FAIL run_old_lo got %h want %h", l, lo_m); end
      end
      IntReq = (bc == 3);
      tick();
    end
    IntReq = 1'b0;
    read_hilo(h, l);
    n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL intreq_run_busy got %0d want 5", bc); end
    n_checks++; if (l !== 32'd42) begin n_fail++; $display("FAIL intreq_run_lo got %h want 42", l); end
    hi_m = 32'd0; lo_m = 32'd42;
  endtask

  task automatic test_reset_mid();
    logic [31:0] h, l;
    start = 1'b1; md_op = MD_DIVU; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_hilo(h, l);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++; if ({h, l} !== 64'd0) begin n_fail++; $display("FAIL rstmid_hilo got %h want 0", {h, l}); end
    repeat (15) tick();
    read_hilo(h, l);
    n_checks++; if ({h, l} !== 64'd0) begin n_fail++; $display("FAIL rstmid_late got %h want 0", {h, l}); end
    hi_m = 32'd0; lo_m = 32'd0;
  endtask

  task automatic test_back_to_back();
    int bc; logic [31:0] h, l;
    do_op(MD_MULTU, 32'd100, 32'd200, bc);
    do_op(MD_DIVU, 32'd50, 32'd8, bc);
    read_hilo(h, l);
    n_checks++; if (bc !== 10) begin n_fail++; $display("FAIL b2b_busy got %0d want 10", bc); end
    n_checks++; if ({h, l} !== {32'd2, 32'd6}) begin n_fail++; $display("FAIL b2b_hilo got %h want %h", {h, l}, {32'd2, 32'd6}); end
    hi_m = 32'd2; lo_m = 32'd6;
  endtask

  task automatic test_random();
    int bc, lat;
    logic [3:0] op; logic [31:0] a, b, h, l;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 11));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 4) == 0) b = 32'hFFFFFFFF;
      model_apply(op, a, b, lat);
      do_op(op, a, b, bc);
      read_hilo(h, l);
      n_checks++; if (bc !== lat) begin n_fail++; $display("FAIL rand_busy op=%0d got %0d want %0d", op, bc, lat); end
      n_checks++; if ({h, l} !== {hi_m, lo_m}) begin n_fail++; $display("FAIL rand_hilo op=%0d a=%h b=%h got %h want %h", op, a, b, {h, l}, {hi_m, lo_m}); end
    end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    int bc; logic [31:0] h, l;
    do_op(MD_MTHI, 32'd0, 32'd0, bc);
    do_op(MD_MTLO, 32'hFFFFFFFF, 32'd0, bc);
    do_op(MD_MADDU, 32'd1, 32'd1, bc);
    read_hilo(h, l);
    n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL maddu_busy got %0d want 5", bc); end
    n_checks++; if ({h, l} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL maddu_hilo got %h want %h", {h, l}, {32'd1, 32'd0}); end
    do_op(MD_MTHI, 32'd0, 32'd0, bc);
    do_op(MD_MTLO, 32'd0, 32'd0, bc);
    do_op(MD_MSUB, 32'd1, 32'd1, bc);
    read_hilo(h, l);
    n_checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFF) begin n_fail++; $display("FAIL msub_hilo got %h want ffffffffffffffff", {h, l}); end
    hi_m = 32'hFFFFFFFF; lo_m = 32'hFFFFFFFF;
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_divzero();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
`ifdef MDU_MADD_EN
    test_madd();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
